meas_window_ctrl: RTL

- Upstream sequencer for the edge-count measurement stage.
- Accepts one command carrying a window length.
- Issues the start and stop pulses on `measure_req_o` spaced by that window, then waits for the stage's response.
- Captures the 16-bit result and offers it downstream on a valid/ready handshake. This keeps the measurement stage's one-cycle result pulse from being lost.

---
 rtl/meas_window_ctrl_if.sv | 35 +++
 rtl/meas_window_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/meas_window_ctrl_if.sv
// Bundle of the command, measurement-stage and result-output signals of
// meas_window_ctrl.
//   master : controller view (drives cmd_ready_o, measure_req_o, out_*, busy_o)
//   slave  : environment view (drives command, stage response, out_ready_i)
// Signal names keep the legacy port names so existing connections map 1:1.
interface meas_window_ctrl_if #(
  parameter int WIN_W = 16
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [WIN_W-1:0] cmd_window_i;
  logic             measure_req_o;
  logic             busy_i;
  logic             result_rsp_i;
  logic [15:0]      result_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [15:0]      out_data_o;
  logic             out_err_o;
  logic             busy_o;

  modport master (
    input  cmd_valid_i, cmd_window_i, busy_i, result_rsp_i, result_data_i,
           out_ready_i,
    output cmd_ready_o, measure_req_o, out_valid_o, out_data_o, out_err_o,
           busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_window_i, busy_i, result_rsp_i, result_data_i,
           out_ready_i,
    input  cmd_ready_o, measure_req_o, out_valid_o, out_data_o, out_err_o,
           busy_o
  );
endinterface

// File: rtl/meas_window_ctrl.sv
// Upstream sequencer for the edge-count measurement stage.
// Accepts one command carrying a window length W. It then emits a start pulse
// and a stop pulse on measure_req_o with max(W,1) low cycles between them. It
// waits for the stage's one-cycle result strobe, and holds the captured
// 16-bit result on a valid/ready output until it is taken.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : meas_window_ctrl_if.master
//              cmd_valid_i/cmd_ready_o/cmd_window_i   command handshake
//              measure_req_o, busy_i                  measurement stage control
//              result_rsp_i/result_data_i             measurement stage result
//              out_valid_o/out_ready_i/out_data_o/
//              out_err_o                              captured result output
//              busy_o                                 controller not idle
//
// Optional feature: define MEAS_WINDOW_CTRL_TIMEOUT_EN to bound the wait for
// the result strobe to TIMEOUT_CYC cycles. On expiry the output carries
// 16'hFFFF with out_err_o=1. Without the macro the wait is unbounded and
// out_err_o is tied 0.
module meas_window_ctrl #(
  parameter int WIN_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                clk,
  input logic                rst,
  meas_window_ctrl_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] WINDOW   = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] WAIT_RSP = 3'd4;
  localparam logic [2:0] HOLD     = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [WIN_W-1:0] win_cnt;
  logic             req_q;
  logic             valid_q;
  logic [15:0]      data_q;
  logic             cmd_ready;
  logic             accept;
  logic             timeout;
  logic             capture;

  assign cmd_ready = (state == IDLE) && !bus.busy_i;
  assign accept    = cmd_ready && bus.cmd_valid_i;
  assign capture   = (state == WAIT_RSP) && (bus.result_rsp_i || timeout);

`ifdef MEAS_WINDOW_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] to_cnt;
  logic          err_q;

  // A strobe in the expiry cycle takes priority over the timeout.
  assign timeout = (state == WAIT_RSP) && !bus.result_rsp_i &&
                   (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != WAIT_RSP) begin
        to_cnt <= '0;
      end else if (!capture) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (capture) begin
        err_q <= timeout;
      end
    end
  end

  assign bus.out_err_o = err_q;
`else
  assign timeout       = 1'b0;
  assign bus.out_err_o = 1'b0;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
    $error("TIMEOUT_CYC must be at least 1");
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = START;
      START:    state_nx = WINDOW;
      WINDOW:   if (win_cnt == WIN_W'(1)) state_nx = STOP;
      STOP:     state_nx = WAIT_RSP;
      WAIT_RSP: if (capture) state_nx = HOLD;
      HOLD:     if (bus.out_ready_i) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      win_cnt <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state <= state_nx;
      // Registered pulse: asserted in the cycle spent in START or STOP.
      req_q <= (state_nx == START) || (state_nx == STOP);

      // Weff is captured directly into the window counter at acceptance and
      // simply held through START, so no separate length register is needed.
      if (accept) begin
        win_cnt <= (bus.cmd_window_i == '0) ? WIN_W'(1) : bus.cmd_window_i;
      end else if (state == WINDOW) begin
        win_cnt <= win_cnt - 1'b1;
      end

      if (capture) begin
        valid_q <= 1'b1;
        data_q  <= timeout ? 16'hFFFF : bus.result_data_i;
      end else if ((state == HOLD) && bus.out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready_o   = cmd_ready;
  assign bus.measure_req_o = req_q;
  assign bus.out_valid_o   = valid_q;
  assign bus.out_data_o    = data_q;
  assign bus.busy_o        = (state != IDLE);

endmodule
